// File: rtl/leaf_spine_uplink.sv
// leaf_spine_uplink: merges NUM_SRC local flit sources onto one spine-facing
// uplink. Arbitration is round-robin. Credit-based flow control keeps the block
// from overrunning the spine port's CREDITS-deep input FIFO. Flits pass through
// unmodified, so the destination address in the header reaches the spine as sent.
//
// Handshake: source i transfers a flit in every cycle where src_valid[i] and
// src_ready[i] are both high at the rising edge. src_ready is a combinational
// grant and never depends on the cycle's own transfer. A source may drop
// src_valid without a transfer at any time and loses nothing. On the uplink,
// up_valid is a one-cycle pulse per flit with no back-pressure, and each
// up_credit_ret pulse returns one FIFO slot.
module leaf_spine_uplink #(
  parameter int DWIDTH  = 16,
  parameter int NUM_SRC = 4,
  parameter int CREDITS = 8,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC*DWIDTH-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic [DWIDTH-1:0]           up_data,
  output logic                        up_valid,
  input  logic                        up_credit_ret,
  output logic [CW-1:0]               credit_count,
  output logic                        credit_err,
  output logic [15:0]                 tx_count,
  output logic [1:0]                  state_dbg
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t            state;
  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     grant_idx;
  logic              grant_found;
  logic              arb_en;
  logic              xfer;
  logic [DWIDTH-1:0] grant_data;
  int                cand;

  assign state_dbg = state;

  // Arbitration is allowed only in RUN while at least one credit is held.
  assign arb_en = (state == RUN) && (credit_count != '0);

  // Rotating priority search: start just after the last winner and wrap around.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = (int'(last_grant) + k) % NUM_SRC;
      if (!grant_found && src_valid[cand[IW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IW-1:0];
      end
    end
  end

  // One-hot grant to the winning source; no grant when arbitration is disabled.
  always_comb begin
    src_ready = '0;
    if (arb_en && grant_found) begin
      src_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer       = arb_en && grant_found;
  assign grant_data = src_data[grant_idx*DWIDTH +: DWIDTH];

  // FSM, send register, credit counter and statistics, all updated on one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= INIT;
      last_grant   <= IW'(NUM_SRC - 1);
      up_data      <= '0;
      up_valid     <= 1'b0;
      credit_count <= CW'(CREDITS);
      credit_err   <= 1'b0;
      tx_count     <= '0;
    end else begin
      // Send path: the flit appears on the uplink one cycle after the transfer.
      up_valid <= xfer;
      if (xfer) begin
        up_data    <= grant_data;
        tx_count   <= tx_count + 16'd1;
        last_grant <= grant_idx;
      end

      // A send and a return in the same cycle cancel out, so no error is raised.
      if (xfer && !up_credit_ret) begin
        credit_count <= credit_count - CW'(1);
      end else if (!xfer && up_credit_ret) begin
        if (credit_count == CW'(CREDITS)) begin
          credit_err <= 1'b1;
        end else begin
          credit_count <= credit_count + CW'(1);
        end
      end

      case (state)
        INIT: state <= RUN;
        RUN: begin
          if (xfer && !up_credit_ret && (credit_count == CW'(1))) begin
            state <= STALL;
          end
        end
        STALL: begin
          if (up_credit_ret) begin
            state <= RUN;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_spine_uplink.sv
// Testbench for leaf_spine_uplink: directed scenarios plus a randomized run
// checked against a behavioural model of credits, priority and flit order.
module tb_leaf_spine_uplink;

  localparam int DW = 16;
  localparam int NS = 4;
  localparam int CR = 8;
  localparam int CW = $clog2(CR + 1);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NS*DW-1:0] src_data = '0;
  logic [NS-1:0]    src_valid = '0;
  logic [NS-1:0]    src_ready;
  logic [DW-1:0]    up_data;
  logic             up_valid;
  logic             up_credit_ret = 1'b0;
  logic [CW-1:0]    credit_count;
  logic             credit_err;
  logic [15:0]      tx_count;
  logic [1:0]       state_dbg;

  leaf_spine_uplink #(.DWIDTH(DW), .NUM_SRC(NS), .CREDITS(CR)) dut (
    .clk(clk),
    .reset(reset),
    .src_data(src_data),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .up_data(up_data),
    .up_valid(up_valid),
    .up_credit_ret(up_credit_ret),
    .credit_count(credit_count),
    .credit_err(credit_err),
    .tx_count(tx_count),
    .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  int            m_credits = CR;
  bit            m_init = 1'b1;
  int            m_last = NS - 1;
  logic [15:0]   m_tx = '0;
  bit            m_err = 1'b0;
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] exp_q[$];

  // The winner is the lowest valid index above the previous winner, or failing
  // that the lowest valid index overall.
  function automatic logic [NS-1:0] model_ready();
    logic [NS-1:0] r;
    int w;
    r = '0;
    w = -1;
    if (m_init || m_credits == 0) return r;
    for (int i = NS - 1; i > m_last; i--) if (src_valid[i]) w = i;
    if (w < 0) for (int i = m_last; i >= 0; i--) if (src_valid[i]) w = i;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  // The block stalls exactly when it holds no credits.
  function automatic logic [1:0] model_state();
    if (m_init) return S_INIT;
    if (m_credits == 0) return S_STALL;
    return S_RUN;
  endfunction

  // Advance one clock. Inputs are sampled mid-cycle and the model is updated
  // just after the edge.
  task automatic tick();
    logic [NS-1:0] r;
    logic [DW-1:0] d;
    int w;
    bit ret;
    bit rst;
    @(negedge clk);
    r = model_ready();
    ret = up_credit_ret;
    rst = reset;
    w = -1;
    d = '0;
    for (int i = 0; i < NS; i++) if (r[i]) w = i;
    if (w >= 0) d = src_data[w*DW +: DW];
    @(posedge clk);
    #1;
    if (rst) begin
      m_credits = CR; m_init = 1'b1; m_last = NS - 1; m_tx = '0;
      m_err = 1'b0; m_valid = 1'b0; m_data = '0;
      exp_q.delete();
    end else begin
      m_init = 1'b0;
      if (w >= 0) begin
        m_valid = 1'b1; m_data = d; m_tx = m_tx + 16'd1; m_last = w;
        exp_q.push_back(d);
      end else begin
        m_valid = 1'b0;
      end
      if (w >= 0 && !ret) m_credits = m_credits - 1;
      else if (w < 0 && ret) begin
        if (m_credits == CR) m_err = 1'b1;
        else m_credits = m_credits + 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_src(input int i, input logic [DW-1:0] v);
    src_data[i*DW +: DW] = v;
  endtask

  task automatic do_reset();
    src_valid = '0;
    up_credit_ret = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    src_valid = '1;
    tick();
    tick();
    n_checks++; if (up_valid !== 1'b0) begin n_fail++; $display("FAIL reset_up_valid got=%0b exp=0", up_valid); end
    n_checks++; if (up_data !== '0) begin n_fail++; $display("FAIL reset_up_data got=%h exp=0", up_data); end
    n_checks++; if (credit_count !== CW'(CR)) begin n_fail++; $display("FAIL reset_credits got=%0d exp=%0d", credit_count, CR); end
    n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", credit_err); end
    n_checks++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL reset_tx got=%0d exp=0", tx_count); end
    n_checks++; if (src_ready !== '0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", src_ready); end
    n_checks++; if (state_dbg !== S_INIT) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, S_INIT); end
    reset = 1'b0;
    #1;
    n_checks++; if (src_ready !== '0) begin n_fail++; $display("FAIL init_ready got=%b exp=0000", src_ready); end
    tick();
    n_checks++; if (state_dbg !== S_RUN) begin n_fail++; $display("FAIL init_to_run got=%0d exp=%0d", state_dbg, S_RUN); end
    n_checks++; if (src_ready !== 4'b0001) begin n_fail++; $display("FAIL first_priority got=%b exp=0001", src_ready); end
    src_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    src_valid = 4'b0001;
    set_src(0, 16'h2A15);
    #1;
    n_checks++; if (src_ready !== 4'b0000) begin n_fail++; $display("FAIL single_init_ready got=%b exp=0000", src_ready); end
    tick();
    n_checks++; if (src_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got=%b exp=0001", src_ready); end
    tick();
    src_valid = '0;
    n_checks++; if (up_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%0b exp=1", up_valid); end
    n_checks++; if (up_data !== 16'h2A15) begin n_fail++; $display("FAIL single_data got=%h exp=2a15", up_data); end
    n_checks++; if (credit_count !== CW'(7)) begin n_fail++; $display("FAIL single_credits got=%0d exp=7", credit_count); end
    n_checks++; if (tx_count !== 16'd1) begin n_fail++; $display("FAIL single_tx got=%0d exp=1", tx_count); end
    tick();
    n_checks++; if (up_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse got=%0b exp=0", up_valid); end
    n_checks++; if (up_data !== 16'h2A15) begin n_fail++; $display("FAIL single_hold got=%h exp=2a15", up_data); end
  endtask

  task automatic test_round_robin();
    int bad_ready;
    int bad_out;
    bad_ready = 0;
    bad_out = 0;
    do_reset();
    src_valid = 4'b1111;
    tick();
    up_credit_ret = 1'b1;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < NS; i++) set_src(i, 16'(16'h1000 * (i + 1) + k));
      #1;
      if (src_ready !== 4'(1 << (k % NS))) begin
        bad_ready++;
        $display("FAIL rr_grant cycle=%0d got=%b exp=%b", k, src_ready, 4'(1 << (k % NS)));
      end
      tick();
      if (up_valid !== 1'b1 || up_data !== 16'(16'h1000 * (k % NS + 1) + k) ||
          credit_count !== CW'(CR) || credit_err !== 1'b0) begin
        bad_out++;
        $display("FAIL rr_out cycle=%0d got=v%0b d%h c%0d e%0b exp=v1 d%h c%0d e0",
                 k, up_valid, up_data, credit_count, credit_err,
                 16'(16'h1000 * (k % NS + 1) + k), CR);
      end
    end
    up_credit_ret = 1'b0;
    src_valid = '0;
    n_checks++; if (bad_ready != 0) n_fail++;
    n_checks++; if (bad_out != 0) n_fail++;
  endtask

  task automatic test_stall();
    int sends;
    sends = 0;
    do_reset();
    src_valid = 4'b0100;
    set_src(2, 16'h0C0C);
    tick();
    for (int k = 0; k < 12; k++) begin
      tick();
      if (up_valid === 1'b1) sends++;
    end
    n_checks++; if (sends != 8) begin n_fail++; $display("FAIL stall_sends got=%0d exp=8", sends); end
    n_checks++; if (credit_count !== CW'(0)) begin n_fail++; $display("FAIL stall_credits got=%0d exp=0", credit_count); end
    n_checks++; if (state_dbg !== S_STALL) begin n_fail++; $display("FAIL stall_state got=%0d exp=%0d", state_dbg, S_STALL); end
    up_credit_ret = 1'b1;
    #1;
    n_checks++; if (src_ready !== '0) begin n_fail++; $display("FAIL stall_ret_ready got=%b exp=0000", src_ready); end
    tick();
    up_credit_ret = 1'b0;
    n_checks++; if (credit_count !== CW'(1) || state_dbg !== S_RUN || up_valid !== 1'b0) begin
      n_fail++; $display("FAIL stall_resume got=c%0d s%0d v%0b exp=c1 s%0d v0", credit_count, state_dbg, up_valid, S_RUN);
    end
    n_checks++; if (src_ready !== 4'b0100) begin n_fail++; $display("FAIL stall_regrant got=%b exp=0100", src_ready); end
    tick();
    n_checks++; if (up_valid !== 1'b1 || credit_count !== CW'(0) || state_dbg !== S_STALL) begin
      n_fail++; $display("FAIL stall_one_more got=v%0b c%0d s%0d exp=v1 c0 s%0d", up_valid, credit_count, state_dbg, S_STALL);
    end
    sends = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (up_valid === 1'b1) sends++;
    end
    n_checks++; if (sends != 0) begin n_fail++; $display("FAIL stall_hold got=%0d exp=0", sends); end
    src_valid = '0;
  endtask

  task automatic test_credit_err();
    do_reset();
    tick();
    n_checks++; if (credit_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got=%0b exp=0", credit_err); end
    up_credit_ret = 1'b1;
    tick();
    up_credit_ret = 1'b0;
    n_checks++; if (credit_err !== 1'b1 || credit_count !== CW'(CR)) begin
      n_fail++; $display("FAIL err_set got=e%0b c%0d exp=e1 c%0d", credit_err, credit_count, CR);
    end
    repeat (3) tick();
    n_checks++; if (credit_err !== 1'b1 || credit_count !== CW'(CR)) begin
      n_fail++; $display("FAIL err_sticky got=e%0b c%0d exp=e1 c%0d", credit_err, credit_count, CR);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    src_valid = 4'b1111;
    tick();
    repeat (3) tick();
    n_checks++; if (credit_count !== CW'(5) || up_valid !== 1'b1) begin
      n_fail++; $display("FAIL burst_pre got=c%0d v%0b exp=c5 v1", credit_count, up_valid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (up_valid !== 1'b0 || credit_count !== CW'(CR) || tx_count !== 16'd0) begin
      n_fail++; $display("FAIL burst_reset got=v%0b c%0d t%0d exp=v0 c%0d t0", up_valid, credit_count, tx_count, CR);
    end
    n_checks++; if (src_ready !== '0 || state_dbg !== S_INIT) begin
      n_fail++; $display("FAIL burst_init got=r%b s%0d exp=r0000 s%0d", src_ready, state_dbg, S_INIT);
    end
    tick();
    n_checks++; if (src_ready !== 4'b0001) begin n_fail++; $display("FAIL burst_priority got=%b exp=0001", src_ready); end
    src_valid = '0;
  endtask

  task automatic test_random();
    int bad;
    logic [DW-1:0] exp_d;
    bad = 0;
    do_reset();
    tick();
    exp_q.delete();
    for (int k = 0; k < 400; k++) begin
      src_valid = NS'($urandom_range(0, (1 << NS) - 1));
      for (int i = 0; i < NS; i++) set_src(i, DW'($urandom()));
      up_credit_ret = ($urandom_range(0, 99) < 45);
      #1;
      if (src_ready !== model_ready()) begin
        bad++; $display("FAIL rand_ready cycle=%0d got=%b exp=%b", k, src_ready, model_ready());
      end
      tick();
      if (up_valid !== m_valid) begin
        bad++; $display("FAIL rand_valid cycle=%0d got=%0b exp=%0b", k, up_valid, m_valid);
      end else if (up_valid === 1'b1) begin
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (up_data !== exp_d) begin bad++; $display("FAIL rand_data cycle=%0d got=%h exp=%h", k, up_data, exp_d); end
      end
      if (credit_count !== CW'(m_credits) || tx_count !== m_tx || credit_err !== m_err || state_dbg !== model_state()) begin
        bad++;
        $display("FAIL rand_state cycle=%0d got=c%0d t%0d e%0b s%0d exp=c%0d t%0d e%0b s%0d",
                 k, credit_count, tx_count, credit_err, state_dbg, m_credits, m_tx, m_err, model_state());
      end
    end
    up_credit_ret = 1'b0;
    src_valid = '0;
    n_checks++; if (bad != 0) n_fail++;
  endtask

  task automatic test_tx_wrap();
    do_reset();
    src_valid = 4'b0001;
    set_src(0, 16'h0005);
    tick();
    up_credit_ret = 1'b1;
    repeat (65535) tick();
    n_checks++; if (tx_count !== 16'hFFFF || credit_count !== CW'(CR) || credit_err !== 1'b0) begin
      n_fail++; $display("FAIL wrap_pre got=t%0d c%0d e%0b exp=t65535 c%0d e0", tx_count, credit_count, credit_err, CR);
    end
    tick();
    n_checks++; if (tx_count !== 16'd0) begin n_fail++; $display("FAIL wrap_zero got=%0d exp=0", tx_count); end
    up_credit_ret = 1'b0;
    src_valid = '0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog_timeout sim_time=%0t limit=5000000", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_credit_err();
    test_reset_mid_burst();
    test_random();
    test_tx_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
